// File: rtl/conv_input_stage_pkg.sv
// Shared widths and address packing for the convolution input stage.
package conv_input_stage_pkg;

    localparam int DW     = 16;
    localparam int ADDR_W = 16;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 8;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two size-deep line buffers turning a raster pixel stream into 3-pixel window columns.
module conv_line_buffer
    import conv_input_stage_pkg::*;
#(
    parameter int SIZE = 14,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    size_i,
    input  logic          pix_v_i,
    input  logic [DW-1:0] pix_i,
    output logic [DW-1:0] out1_o,
    output logic [DW-1:0] out2_o,
    output logic [DW-1:0] out3_o,
    output logic          srt_o
);

    localparam int IW = $clog2(SIZE);

    logic [DW-1:0]    lb1_q [SIZE];
    logic [DW-1:0]    lb2_q [SIZE];
    logic [IW-1:0]    tap_idx;
    logic [DW-1:0]    tap1;
    logic [DW-1:0]    tap2;
    logic [ROW_W-1:0] r_q, r_d;
    logic [COL_W-1:0] c_q, c_d;

    // Tap at depth size-1 is read before the shift, i.e. the pixel exactly one row earlier.
    assign tap_idx = IW'(size_i - 8'd1);
    assign tap1    = lb1_q[tap_idx];
    assign tap2    = lb2_q[tap_idx];

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (pix_v_i) begin
            if (c_q == size_i - 8'd1) begin
                c_d = '0;
                r_d = (r_q == size_i - 8'd1) ? '0 : r_q + 8'd1;
            end else begin
                c_d = c_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
            r_q    <= '0;
            c_q    <= '0;
            out1_o <= '0;
            out2_o <= '0;
            out3_o <= '0;
            srt_o  <= 1'b0;
        end else begin
            r_q   <= r_d;
            c_q   <= c_d;
            srt_o <= pix_v_i && (r_q >= 8'd2);
            if (pix_v_i) begin
                lb1_q[0] <= pix_i;
                lb2_q[0] <= tap1;
                for (int i = 1; i < SIZE; i++) begin
                    lb1_q[i] <= lb1_q[i-1];
                    lb2_q[i] <= lb2_q[i-1];
                end
                out1_o <= tap2;
                out2_o <= tap1;
                out3_o <= pix_i;
            end
        end
    end

endmodule

// File: rtl/conv_input_stage.sv
// Raster address counter, image memory and line-buffer front end of the 3x3 conv datapath.
module conv_input_stage
    import conv_input_stage_pkg::*;
#(
    parameter int SIZE = 14,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    size,
    input  logic          enable,
    input  logic          we,
    input  logic [DW-1:0] data_in,
    input  logic          load,
    output logic [15:0]   addr,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic          srt_sig
);

    localparam int              DEPTH  = SIZE * SIZE;
    localparam int              AW     = $clog2(DEPTH);
    localparam logic [7:0]      SIZE_L = 8'(SIZE);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             in_range;
    logic [AW-1:0]    mem_idx;
    logic [DW-1:0]    mem [DEPTH];
    logic [DW-1:0]    rd_data_q;
    logic             rd_v_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (enable) begin
            if (col_q == size - 8'd1) begin
                col_d = '0;
                row_d = (row_q == size - 8'd1) ? '0 : row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            rd_v_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            rd_v_q <= load & enable & ~we;
        end
    end

    assign addr     = pack_addr(row_q, col_q);
    assign in_range = (row_q < SIZE_L) && (col_q < SIZE_L);
    assign mem_idx  = AW'(16'(row_q) * 16'(SIZE) + 16'(col_q));

    // Memory array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (we && enable && in_range) begin
            mem[mem_idx] <= data_in;
        end
        rd_data_q <= in_range ? mem[mem_idx] : '0;
    end

    conv_line_buffer #(
        .SIZE (SIZE),
        .DW   (DW)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .size_i  (size),
        .pix_v_i (rd_v_q),
        .pix_i   (rd_data_q),
        .out1_o  (out1),
        .out2_o  (out2),
        .out3_o  (out3),
        .srt_o   (srt_sig)
    );

endmodule

// File: tb/tb_conv_input_stage.sv
// Scoreboard bench: driver pushes expected window columns, a monitor pops them on srt_sig.
module tb_conv_input_stage;

    localparam int SIZE = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  size = 8'd14;
    logic        enable = 1'b0;
    logic        we = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] addr;
    logic [15:0] out1, out2, out3;
    logic        srt_sig;

    always #5 clk = ~clk;

    conv_input_stage #(.SIZE(SIZE), .DW(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .size    (size),
        .enable  (enable),
        .we      (we),
        .data_in (data_in),
        .load    (load),
        .addr    (addr),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .srt_sig (srt_sig)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          srt_cnt = 0;
    logic [15:0] mem_m [SIZE*SIZE];
    int          m_row = 0;
    int          m_col = 0;
    logic [15:0] hist [$];
    logic [47:0] exp_q [$];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    // One clock of stimulus; the reference model sees the same inputs the DUT samples next edge.
    task automatic step(input bit en, input bit w, input bit ld, input logic [15:0] d);
        int sz;
        int k;
        logic [15:0] v;
        @(negedge clk);
        chk("addr", 48'({8'(m_row), 8'(m_col)}), 48'(addr));
        enable  = en;
        we      = w;
        load    = ld;
        data_in = d;
        sz = int'(size);
        if (en && w) begin
            if (m_row < SIZE && m_col < SIZE) mem_m[m_row*SIZE + m_col] = d;
        end else if (en && ld) begin
            v = (m_row < SIZE && m_col < SIZE) ? mem_m[m_row*SIZE + m_col] : 16'd0;
            hist.push_back(v);
            k = hist.size() - 1;
            if ((k / sz) % sz >= 2) exp_q.push_back({hist[k-2*sz], hist[k-sz], hist[k]});
        end
        if (en) begin
            m_col++;
            if (m_col == sz) begin
                m_col = 0;
                m_row++;
                if (m_row == sz) m_row = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 48'(addr), 48'd0);
        chk({tag, "_out1"}, 48'(out1), 48'd0);
        chk({tag, "_out2"}, 48'(out2), 48'd0);
        chk({tag, "_out3"}, 48'(out3), 48'd0);
        chk({tag, "_srt"},  48'(srt_sig), 48'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && srt_sig) begin
            srt_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL srt_unexpected at %0t: got srt_sig=1 with window %0d/%0d/%0d, expected srt_sig=0",
                         $time, out1, out2, out3);
            end else begin
                chk("window", {out1, out2, out3}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        #1 rst_n = 1'b0;
        #2 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Load the image in raster order, value = linear index.
        for (int k = 0; k < SIZE*SIZE; k++) step(1'b1, 1'b1, 1'b0, 16'(k));
        idle(1);

        c0 = srt_cnt;
        for (int k = 0; k < SIZE*SIZE; k++) step(1'b1, 1'b0, 1'b1, 16'd0);
        idle(3);
        chk("srt_count_frame1", 48'(srt_cnt - c0), 48'd168);

        // Second frame with a 3-cycle enable drop in row 4.
        c0 = srt_cnt;
        for (int k = 0; k < SIZE*SIZE; k++) begin
            if (k == 4*SIZE + 6) begin
                for (int p = 0; p < 3; p++) step(1'b0, 1'b0, 1'b1, 16'd0);
                n = hist.size() - 1;
                chk("pause_srt", 48'(srt_sig), 48'd0);
                chk("pause_hold", {out1, out2, out3}, {hist[n-2*SIZE], hist[n-SIZE], hist[n]});
            end
            step(1'b1, 1'b0, 1'b1, 16'd0);
        end
        idle(3);
        chk("srt_count_frame2", 48'(srt_cnt - c0), 48'd168);

        // Reset part-way through a frame.
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b1, 16'd0);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        hist.delete();
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        enable = 1'b0;
        load = 1'b0;
        @(negedge clk);
        size = 8'd5;
        @(negedge clk);
        rst_n = 1'b1;

        // Small image: contents retained from before the reset.
        c0 = srt_cnt;
        for (int k = 0; k < 25; k++) step(1'b1, 1'b0, 1'b1, 16'd0);
        idle(3);
        chk("srt_count_size5", 48'(srt_cnt - c0), 48'd15);

        // we and load together: memory written, nothing streamed.
        for (int k = 0; k < 25; k++) begin
            step(1'b1, 1'b1, 1'b1, 16'($urandom));
            chk("we_load_srt", 48'(srt_sig), 48'd0);
        end

        // Random enable/load gaps over the rewritten image.
        for (int k = 0; k < 120; k++) begin
            step(($urandom % 4) != 0, 1'b0, ($urandom % 5) != 0, 16'($urandom));
        end
        idle(3);
        chk("scoreboard_drained", 48'(exp_q.size()), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_input_stage.md
Name: conv_input_stage

Overview:
Front end of the 3x3 convolution datapath. It combines three functions:
- a row/column address counter;
- a single-port 16-bit image memory, written in raster order during a load phase;
- a line-buffer stage that streams the stored image back and presents three vertically adjacent pixels per column.
These three pixels are the column slices of a 3x3 window and feed the MAC array downstream.

Parameters:
SIZE, 14, maximum image side in pixels (padding included); memory depth SIZE*SIZE.
DW, 16, pixel data width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous and active-low.
size  in  8  runtime image side; legal range 3..SIZE; held static while enable=1.
enable  in  1  counter advance and phase-qualify.
we  in  1  write phase: data_in is stored at the current addr.
data_in  in  DW  pixel to write.
load  in  1  read/stream phase request.
addr  out  16  current address, {row[7:0], col[7:0]}.
out1  out  DW  pixel at (r-2, c).
out2  out  DW  pixel at (r-1, c).
out3  out  DW  pixel at (r, c).
srt_sig  out  1  out1..out3 form a valid window column this cycle.

Behaviour:
- Reset: addr=0, out1..out3=0, srt_sig=0, line buffers cleared, pipeline valids cleared. Memory contents are not reset. Reset asserted mid-operation aborts immediately; the next frame starts at (0,0).
- Counter:
  - On each edge with enable=1: col increments.
  - At col=size-1: col returns to 0 and row increments.
  - At (size-1, size-1): wraps to (0,0).
  - With enable=0 the counter holds.
- Memory write: on an edge with we=1 and enable=1, mem[row*SIZE+col] <= data_in. Writes with row or col >= SIZE are ignored.
- Memory read: registered read, so data_out = mem[addr of the previous cycle]. Out-of-range addresses read 0.
- Read valid: rd_v <= load & enable & ~we, registered so it aligns with data_out. When we and load are both high, we wins and no stream data is produced.
- Line-buffer stage (one pixel per rd_v cycle; pixel at (r,c) arrives in raster order):
  - out3 <= pixel; out2 <= line buffer 1 tap (r-1,c); out1 <= line buffer 2 tap (r-2,c).
  - Each line buffer is a size-deep shift register of DW bits. It shifts only on rd_v.
  - Internal r/c counters track the incoming pixel and wrap at size the same way as the address counter.
- srt_sig:
  - Registered with out1..out3, so it is high in the same cycle as the data.
  - Equals 1 when a pixel with r >= 2 was accepted that cycle; 0 otherwise, including on any cycle with rd_v=0.
- Latency: addr at cycle t -> memory data at t+1 -> out1..out3/srt_sig at t+2.
- When load or enable drops: outputs hold their last values, srt_sig=0, and the internal r/c counters and buffers freeze. Streaming resumes seamlessly.
- Frame wrap: after pixel (size-1, size-1), r/c return to 0. srt_sig stays low for rows 0 and 1 of the next frame, because the stale buffer contents must not be flagged valid.
- Widths: no arithmetic on pixel data; values pass through unchanged (signed interpretation is irrelevant).

Decomposition:
- Shared package: DW=16, ADDR_W=16, ROW_W=COL_W=8, and the {row,col} address packing helper.
- One natural sub-module: conv_line_buffer. It contains the two line buffers, the r/c tracking and srt_sig generation.
- The counter and memory are small enough to remain inline in conv_input_stage.

Test Plan:
- Write phase, SIZE=size=14: we=1, enable=1, data_in=0..195 in raster order -> mem[k]=k; addr runs 0x0000..0x0D0D, then wraps to 0x0000.
- Stream phase: load=1, enable=1, we=0 -> srt_sig first high 2 cycles after addr=0x0200; that cycle out1=0, out2=14, out3=28. At pixel (2,5): 5/19/33. Last pixel (13,13): 167/181/195, with srt_sig high for exactly 12*14=168 cycles per frame.
- Pause: drop enable for 3 cycles mid-row 4 -> addr holds, srt_sig=0, outputs hold; after resume the sequence continues with no skipped or duplicated pixel.
- we=1 and load=1 together -> memory written, srt_sig stays 0.
- size=5 with SIZE=14 -> counter wraps col at 4 and row at 4; the first valid column is out1/out2/out3 = mem(0,0)/mem(1,0)/mem(2,0).
- Assert rst_n=0 mid-stream -> addr, outputs and srt_sig are 0 asynchronously; memory contents are retained.
